// File: rtl/tx_burst_sequencer_pkg.sv
// Shared constants and helpers for the TX burst sequencer.
// State codes, symbol values and a width helper.
package tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEAD    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_TAIL    = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic TAIL_SYM = 1'b0;
  localparam logic FILL_SYM = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_burst_sequencer_if.sv
// Burst sequencer bus: control, payload stream,
// modulator handshake and RF chain I/Q.
interface tx_burst_sequencer_if #(
  parameter int IQ_WIDTH  = 8,
  parameter int LEN_WIDTH = 10
);
  logic                 fire_burst;
  logic                 abort;
  logic [LEN_WIDTH-1:0] burst_length;
  logic                 is_armed;
  logic                 bit_valid;
  logic                 bit_data;
  logic                 bit_ready;
  logic                 underrun;
  logic                 sample_strobe;
  logic                 symbol_input_strobe;
  logic                 symbol_iq_strobe;
  logic                 current_symbol;
  logic [IQ_WIDTH-1:0]  modulator_inphase;
  logic [IQ_WIDTH-1:0]  modulator_quadrature;
  logic [IQ_WIDTH-1:0]  rfchain_inphase;
  logic [IQ_WIDTH-1:0]  rfchain_quadrature;
  logic                 iq_valid;

  modport slave (
    input  fire_burst, abort, burst_length,
    input  bit_valid, bit_data,
    input  symbol_input_strobe, symbol_iq_strobe,
    input  modulator_inphase, modulator_quadrature,
    output is_armed, bit_ready, underrun,
    output sample_strobe, current_symbol,
    output rfchain_inphase, rfchain_quadrature,
    output iq_valid
  );

  modport master (
    output fire_burst, abort, burst_length,
    output bit_valid, bit_data,
    output symbol_input_strobe, symbol_iq_strobe,
    output modulator_inphase, modulator_quadrature,
    input  is_armed, bit_ready, underrun,
    input  sample_strobe, current_symbol,
    input  rfchain_inphase, rfchain_quadrature,
    input  iq_valid
  );
endinterface

// File: rtl/tx_burst_sequencer_sample_divider.sv
// Free-running sample strobe: one-cycle pulse
// every SAMPLE_DIV clocks, first one SAMPLE_DIV clocks out of reset.
module sample_divider
  import tx_pkg::*;
#(
  parameter int SAMPLE_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic strobe_o
);
  localparam int DW = (clog2(SAMPLE_DIV) > 0)
                    ? clog2(SAMPLE_DIV) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          wrap;

  assign wrap = (cnt_q == DW'(SAMPLE_DIV - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + DW'(1);
    stb_d = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign strobe_o = stb_q;
endmodule

// File: rtl/tx_burst_sequencer.sv
// Burst framer: head zeros, payload, tail zeros,
// with I/Q gating onto the RF chain while the burst is on air.
module tx_burst_sequencer
  import tx_pkg::*;
#(
  parameter int IQ_WIDTH   = 8,
  parameter int LEN_WIDTH  = 10,
  parameter int TAIL_BITS  = 3,
  parameter int SAMPLE_DIV = 4
) (
  input logic            clock_i,
  input logic            reset_ni,
  tx_burst_sequencer_if.slave bus
);
  localparam int TW = clog2(TAIL_BITS + 1);
  localparam int CW = (LEN_WIDTH > TW) ? LEN_WIDTH : TW;
  localparam int IW = LEN_WIDTH + 1;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [IW-1:0]        iqc_q, iqc_d;
  logic                 iqv_q, iqv_d;
  logic                 sym_q, sym_d;
  logic                 und_q, und_d;
  logic [IQ_WIDTH-1:0]  rfi_q, rfi_d;
  logic [IQ_WIDTH-1:0]  rfq_q, rfq_d;
  logic [IW-1:0]        iq_n;
  logic                 iq_hit, iq_done;
  logic                 sis, stb;
  logic [2:0]           first_st;

  sample_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .strobe_o (stb)
  );

  assign sis  = bus.symbol_input_strobe;
  assign iq_n = IW'(2 * TAIL_BITS) + IW'(len_q);

  // current_symbol is a lookahead register: fire already
  // loads the first head zero, so HEAD loads the rest.
  assign first_st = (TAIL_BITS > 1) ? ST_HEAD
                  : (bus.burst_length == '0) ? ST_TAIL
                  : ST_PAYLOAD;

  assign iq_hit  = bus.symbol_iq_strobe
                && (state_q != ST_IDLE)
                && (iqc_q <= iq_n);
  assign iq_done = (iqc_q > iq_n)
                || (iq_hit && iqc_q == iq_n);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    iqc_d   = iqc_q;
    iqv_d   = iqv_q;
    sym_d   = sym_q;
    und_d   = 1'b0;

    if (iq_hit) begin
      iqc_d = iqc_q + IW'(1);
      if (iqc_q == '0) iqv_d = 1'b1;
      if (iqc_q == iq_n) iqv_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.fire_burst) begin
          len_d   = bus.burst_length;
          cnt_d   = (TAIL_BITS > 1) ? CW'(1) : '0;
          iqc_d   = '0;
          iqv_d   = 1'b0;
          sym_d   = TAIL_SYM;
          state_d = first_st;
        end
      end
      ST_HEAD: begin
        if (sis) begin
          sym_d = TAIL_SYM;
          if (cnt_q == CW'(TAIL_BITS - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? ST_TAIL
                                    : ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (sis) begin
          sym_d = bus.bit_valid ? bus.bit_data : FILL_SYM;
          und_d = !bus.bit_valid;
          if (cnt_q + CW'(1) == CW'(len_q)) begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_TAIL: begin
        if (sis) begin
          sym_d = TAIL_SYM;
          if (cnt_q == CW'(TAIL_BITS)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        sym_d = TAIL_SYM;
        if (iq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      iqc_d   = '0;
      iqv_d   = 1'b0;
      sym_d   = TAIL_SYM;
      und_d   = 1'b0;
    end

    rfi_d = rfi_q;
    rfq_d = rfq_q;
    if (stb && iqv_q) begin
      rfi_d = bus.modulator_inphase;
      rfq_d = bus.modulator_quadrature;
    end
    if (!iqv_d) begin
      rfi_d = '0;
      rfq_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      iqc_q   <= '0;
      iqv_q   <= 1'b0;
      sym_q   <= TAIL_SYM;
      und_q   <= 1'b0;
      rfi_q   <= '0;
      rfq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      iqc_q   <= iqc_d;
      iqv_q   <= iqv_d;
      sym_q   <= sym_d;
      und_q   <= und_d;
      rfi_q   <= rfi_d;
      rfq_q   <= rfq_d;
    end
  end

  assign bus.is_armed           = (state_q == ST_IDLE);
  assign bus.bit_ready          = (state_q == ST_PAYLOAD) && sis;
  assign bus.underrun           = und_q;
  assign bus.sample_strobe      = stb;
  assign bus.current_symbol     = sym_q;
  assign bus.rfchain_inphase    = rfi_q;
  assign bus.rfchain_quadrature = rfq_q;
  assign bus.iq_valid           = iqv_q;
endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Self-checking bench for tx_burst_sequencer: index-based
// burst model, per-cycle compare, directed and random bursts.
module tb_tx_burst_sequencer;
  localparam int IQW = 8;
  localparam int LW  = 10;
  localparam int T   = 3;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_burst_sequencer_if #(.IQ_WIDTH(IQW), .LEN_WIDTH(LW)) bus ();

  tx_burst_sequencer #(
    .IQ_WIDTH(IQW), .LEN_WIDTH(LW),
    .TAIL_BITS(T), .SAMPLE_DIV(DIV)
  ) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_edges = 0;
  bit m_armed = 1, m_active = 0, m_iqv = 0, m_under = 0;
  int m_len = 0, m_n = 0, m_deliv = 0, m_iqn = 0, m_p = 0, m_h = 0;
  logic [IQW-1:0] m_rfi = '0, m_rfq = '0;
  bit m_stream [0:1100];

  function automatic bit exp_ready();
    return m_active && bus.symbol_input_strobe && m_deliv < m_n
        && (m_deliv + 1) >= T && (m_deliv + 1) < T + m_len;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0; m_armed = 1; m_active = 0; m_iqv = 0;
      m_under = 0; m_rfi = '0; m_rfq = '0;
    end else begin
      bit s_pre, rdy, nxt;
      s_pre = (m_edges > 0) && (m_edges % DIV == 0);
      m_edges++;
      rdy = exp_ready();
      nxt = m_iqv;
      m_under = 0;
      if (bus.abort) begin
        m_active = 0; m_armed = 1; nxt = 0;
      end else if (m_armed && bus.fire_burst) begin
        m_armed = 0; m_active = 1;
        m_len = int'(bus.burst_length);
        m_n = 2 * T + m_len;
        m_deliv = 0; m_iqn = 0; m_p = 0; m_h = 0;
        for (int i = 0; i < m_n; i++) m_stream[i] = 0;
      end else if (m_active) begin
        if (m_deliv == m_n &&
            (m_iqn > m_n || (bus.symbol_iq_strobe && m_iqn == m_n))) begin
          m_active = 0; m_armed = 1;
        end
        if (bus.symbol_iq_strobe && m_iqn <= m_n) begin
          m_iqn++;
          if (m_iqn == 1) nxt = 1;
          if (m_iqn == m_n + 1) nxt = 0;
        end
        if (bus.symbol_input_strobe && m_deliv < m_n) begin
          if (rdy) begin
            m_stream[m_deliv + 1] = bus.bit_valid ? bus.bit_data : 1'b1;
            m_under = !bus.bit_valid;
            m_p++;
            if (bus.bit_valid) m_h++;
          end
          m_deliv++;
        end
      end
      if (!nxt) begin
        m_rfi = '0; m_rfq = '0;
      end else if (s_pre && m_iqv) begin
        m_rfi = bus.modulator_inphase;
        m_rfq = bus.modulator_quadrature;
      end
      m_iqv = nxt;
    end
  end

  // ---------------- observation ----------------
  bit log_q [$];
  int hs_cnt = 0, un_cnt = 0, span_cnt = 0;

  always @(negedge clk) begin
    bit cur_e;
    cur_e = (m_active && m_deliv < m_n) ? m_stream[m_deliv] : 1'b0;
    chk("sample_strobe", 32'(bus.sample_strobe),
        32'((m_edges > 0) && (m_edges % DIV == 0)));
    chk("is_armed", 32'(bus.is_armed), 32'(m_armed));
    chk("iq_valid", 32'(bus.iq_valid), 32'(m_iqv));
    chk("current_symbol", 32'(bus.current_symbol), 32'(cur_e));
    chk("bit_ready", 32'(bus.bit_ready), 32'(exp_ready()));
    chk("underrun", 32'(bus.underrun), 32'(m_under));
    chk("rf_i", 32'(bus.rfchain_inphase), 32'(m_rfi));
    chk("rf_q", 32'(bus.rfchain_quadrature), 32'(m_rfq));
    if (m_active && bus.symbol_input_strobe && m_deliv < m_n
        && !bus.abort)
      log_q.push_back(bus.current_symbol);
    if (bus.bit_ready && bus.bit_valid) hs_cnt++;
    if (bus.underrun) un_cnt++;
    if (bus.symbol_iq_strobe && bus.iq_valid) span_cnt++;
  end

  // ---------------- input drivers ----------------
  bit rand_mode = 0;
  bit pay [32];
  int drop_idx = -1;
  bit sd1 = 0, sd2 = 0;

  always @(posedge clk) begin
    bit s;
    #1;
    s = ($urandom % 3) == 0;
    bus.symbol_iq_strobe = sd2;
    sd2 = sd1;
    sd1 = s;
    bus.symbol_input_strobe = s;
    bus.modulator_inphase = IQW'($urandom);
    bus.modulator_quadrature = IQW'($urandom);
    if (rand_mode) begin
      bus.bit_data = 1'($urandom);
      bus.bit_valid = ($urandom % 8) != 0;
    end else begin
      bus.bit_data = pay[m_h & 31];
      bus.bit_valid = (m_p != drop_idx);
    end
  end

  task automatic start_burst(input int len);
    @(posedge clk); #1;
    log_q.delete();
    hs_cnt = 0; un_cnt = 0; span_cnt = 0;
    bus.fire_burst = 1'b1;
    bus.burst_length = LW'(len);
    @(posedge clk); #1;
    bus.fire_burst = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (m_active && t < 4000) begin
      @(posedge clk); t++;
    end
    chk(nm, 32'(t < 4000), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] log_vec();
    logic [31:0] v;
    v = '0;
    foreach (log_q[i]) v = {v[30:0], log_q[i]};
    return v;
  endfunction

  initial begin
    int sc, t;
    bus.fire_burst = 0; bus.abort = 0; bus.burst_length = '0;
    bus.bit_valid = 0; bus.bit_data = 0;
    bus.symbol_input_strobe = 0; bus.symbol_iq_strobe = 0;
    bus.modulator_inphase = '0; bus.modulator_quadrature = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset: strobes at clocks 4,8,...,20
    sc = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      sc += int'(bus.sample_strobe);
    end
    chk("idle_strobes", 32'(sc), 32'd5);
    chk("idle_armed", 32'(bus.is_armed), 32'd1);
    chk("idle_iqv", 32'(bus.iq_valid), 32'd0);

    // len 8, payload 10110010
    {pay[0], pay[1], pay[2], pay[3]} = 4'b1011;
    {pay[4], pay[5], pay[6], pay[7]} = 4'b0010;
    drop_idx = -1;
    start_burst(8);
    wait_done("b8_timeout");
    chk("b8_len", 32'(log_q.size()), 32'd14);
    chk("b8_syms", log_vec(), 32'b00010110010000);
    chk("b8_hs", 32'(hs_cnt), 32'd8);
    chk("b8_span", 32'(span_cnt), 32'd14);
    chk("b8_rearm", 32'(bus.is_armed), 32'd1);

    // len 4, second bit missing
    {pay[0], pay[1], pay[2], pay[3]} = 4'b1001;
    drop_idx = 1;
    start_burst(4);
    wait_done("b4_timeout");
    chk("b4_syms", log_vec(), 32'b0001100000);
    chk("b4_len", 32'(log_q.size()), 32'd10);
    chk("b4_underrun", 32'(un_cnt), 32'd1);
    drop_idx = -1;

    // len 0
    start_burst(0);
    wait_done("b0_timeout");
    chk("b0_len", 32'(log_q.size()), 32'd6);
    chk("b0_syms", log_vec(), 32'd0);
    chk("b0_span", 32'(span_cnt), 32'd6);
    chk("b0_hs", 32'(hs_cnt), 32'd0);

    // abort while loading the third payload bit
    start_burst(8);
    t = 0;
    while (m_p < 2 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("ab_reach", 32'(t < 2000), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("ab_iqv", 32'(bus.iq_valid), 32'd0);
    chk("ab_rfi", 32'(bus.rfchain_inphase), 32'd0);
    chk("ab_rfq", 32'(bus.rfchain_quadrature), 32'd0);
    chk("ab_armed", 32'(bus.is_armed), 32'd1);
    start_burst(5);
    wait_done("ab_clean_timeout");
    chk("ab_clean_len", 32'(log_q.size()), 32'd11);
    chk("ab_clean_hs", 32'(hs_cnt), 32'd5);

    // fire and length change mid-burst are ignored
    start_burst(4);
    repeat (6) @(posedge clk);
    #1;
    bus.fire_burst = 1'b1;
    bus.burst_length = LW'(9);
    @(posedge clk); #1;
    bus.fire_burst = 1'b0;
    wait_done("mid_timeout");
    chk("mid_len", 32'(log_q.size()), 32'd10);

    // fire with abort while idle
    @(posedge clk); #1;
    bus.fire_burst = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.fire_burst = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("fa_armed", 32'(bus.is_armed), 32'd1);
    chk("fa_iqv", 32'(bus.iq_valid), 32'd0);

    // random traffic
    rand_mode = 1;
    repeat (4000) begin
      @(posedge clk); #1;
      bus.fire_burst = m_armed ? (($urandom % 6) == 0)
                               : (($urandom % 50) == 0);
      bus.abort = ($urandom % 300) == 0;
      bus.burst_length = LW'($urandom_range(0, 12));
    end
    @(posedge clk); #1;
    bus.fire_burst = 0;
    bus.abort = 0;
    wait_done("rand_timeout");
    chk("rand_armed", 32'(bus.is_armed), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_burst_sequencer.md
# tx_burst_sequencer

Parametrised successor to the single-burst TX controller that sits between the payload bit source, the GMSK modulator and the RF chain. It generates the sample strobe and frames each burst as head tail-bits, a variable-length payload and closing tail-bits. It gates modulator I/Q onto the RF chain only while burst symbols are on air, then re-arms. It adds runtime burst length, payload flow control with underrun reporting, abort, and parametrised I/Q width and sample rate.

## Interface
- IQ_WIDTH, 8, I/Q sample width
- LEN_WIDTH, 10, width of burst_length
- TAIL_BITS, 3, zero symbols before and after payload (≥1)
- SAMPLE_DIV, 4, clocks per sample_strobe (≥2)
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fire_burst  in  1  start request, honoured only while is_armed
- abort  in  1  synchronous abort, any state
- burst_length  in  LEN_WIDTH  payload bit count, captured on accepted fire
- is_armed  out  1  high in IDLE
- bit_valid / bit_data  in  1 / 1  payload bit stream
- bit_ready  out  1  combinational: PAYLOAD && symbol_input_strobe
- underrun  out  1  one-cycle pulse when a payload bit was needed and bit_valid=0
- sample_strobe  out  1  one-cycle pulse every SAMPLE_DIV clocks
- symbol_input_strobe  in  1  modulator takes current_symbol this cycle
- symbol_iq_strobe  in  1  modulator I/Q now reflects a new symbol
- current_symbol  out  1  registered next symbol
- modulator_inphase / modulator_quadrature  in  IQ_WIDTH each
- rfchain_inphase / rfchain_quadrature  out  IQ_WIDTH each
- iq_valid  out  1  RF chain enable

## Operation
- States: IDLE, HEAD, PAYLOAD, TAIL, DRAIN.
- IDLE: is_armed=1, current_symbol=0. fire_burst=1 captures burst_length into len_q, clears counters, and moves to HEAD.
- Each symbol_input_strobe delivers current_symbol. The register updates on that edge to the symbol for the next delivery.
- HEAD delivers TAIL_BITS zeros. It then moves to PAYLOAD, or to TAIL if len_q=0.
- PAYLOAD delivers len_q bits. A handshake (bit_valid && bit_ready) supplies bit_data. If bit_valid=0, symbol 1 is delivered, underrun pulses, and the count still advances.
- TAIL delivers TAIL_BITS zeros, then moves to DRAIN.
- DRAIN: symbol_input_strobe is ignored and current_symbol=0.
- iq counter counts symbol_iq_strobe pulses after fire. iq_valid sets on pulse 1 and clears on pulse N+1, where N = 2·TAIL_BITS + len_q. Clearing iq_valid in DRAIN returns to IDLE.
- rfchain_* registers modulator_* on sample_strobe while iq_valid=1. They are forced to 0 whenever iq_valid=0.
- abort: next state IDLE; iq_valid, rfchain_* and current_symbol go to 0 the next cycle. bit_ready stays 0 from that cycle on.
- Symbol counter width is max(LEN_WIDTH, clog2(TAIL_BITS+1)). The iq counter is LEN_WIDTH+1 bits, so no wrap-around.

## Timing
- Reset values: state IDLE, is_armed=1, current_symbol=0, iq_valid=0, rfchain_*=0, underrun=0, sample divider=0, sample_strobe=0.
- sample_strobe first fires SAMPLE_DIV clocks after reset release. The divider is free-running and unaffected by fire/abort.
- is_armed falls the cycle after the accepted fire.
- fire and abort in the same cycle: abort wins, stays IDLE.
- fire while not armed is ignored.
- A symbol_input_strobe in the same cycle as the accepted fire is not a burst delivery. The first delivery is the next strobe.
- Last TAIL delivery and its state change happen on the same edge.
- A burst_length change mid-burst has no effect.
- iq_valid and rfchain_* change registered, one cycle after the causing strobe.

## Structure
- Shared package tx_pkg: state enum, symbol constants (TAIL_SYM=0, FILL_SYM=1), clog2 helper.
- Sub-module sample_divider (SAMPLE_DIV parameter, free-running strobe). Everything else is in one FSM module.

## Test plan
- Reset, then idle 20 clocks with SAMPLE_DIV=4: sample_strobe pulses at clocks 4, 8, …; is_armed=1; rfchain_*=0, iq_valid=0.
- burst_length=8, payload 10110010, bit_valid always 1, TAIL_BITS=3: delivered symbols 000 10110010 000. Exactly 8 bit_ready handshakes. iq_valid is high for exactly 14 iq strobes; re-armed after.
- burst_length=4, bit_valid dropped for 2nd bit: delivered payload b0,1,b1,b2. One underrun pulse. No symbol slip.
- burst_length=0: delivered 000000, iq_valid spans 6 iq strobes, bit_ready never asserts.
- abort during PAYLOAD (3rd bit): next cycle iq_valid=0, rfchain_*=0, is_armed=1. A subsequent fire runs a full clean burst.
- fire during burst and fire+abort together in IDLE: both ignored, no state change.
